clock_set_controller: RTL and testbench
=======================================

// Module: clock_set_controller
// PURPOSE
//  Parametrised successor of the clock-setting FSM. It debounces a mode switch and an adjust switch.
//  It steps through the settable clock fields (field 0 = seconds, reset-only; fields 1..NUM_FIELDS-1
//  are settable) and issues single or auto-repeat increment pulses to the selected field.
//  It times out back to run mode. It sits between the raw board switches and the counter chain / display.
// PARAMETERS
//  NUM_FIELDS      3       number of counter fields (>=2); bit k of field vectors = field k
//  DEBOUNCE_CYCLES 500000  consecutive stable synced samples needed to accept a switch change (>=1)
//  REPEAT_DELAY    25000000 cycles from first adjust pulse to first auto-repeat pulse (>=1)
//  REPEAT_PERIOD   5000000 cycles between subsequent auto-repeat pulses (>=1)
//  TIMEOUT_CYCLES  500000000 idle cycles in a SET state before returning to IDLE; 0 disables
// PORTS
//  i_Clock                      in   1           single system clock, rising edge
//  i_Reset_n                    in   1           asynchronous, active-low reset
//  i_Switch                     in   1           raw mode switch, active high, asynchronous
//  i_Adjust                     in   1           raw adjust switch, active high, asynchronous
//  o_Counters_Reset             out  1           clear field 0 (seconds)
//  o_Counters_Enable_Increment  out  1           one-cycle increment strobe to the selected field
//  o_Counters_Enable_Count      out  NUM_FIELDS  per-field count enable
//  o_Display_Blink              out  NUM_FIELDS  one-hot: field under edit blinks
//  o_Display_Enable_Dot         out  1           seconds dot enable (run mode only)
// BEHAVIOUR
//  Reset (i_Reset_n=0, no clock needed): state=IDLE; synchronisers, debounced levels, all counters=0.
//   Outputs: Reset=0, Increment=0, Enable_Count=all 1s, Blink=0, Dot=1.
//  Input path, per switch: 2-flop synchroniser, then a debounce counter.
//   The counter advances while synced != debounced level and clears otherwise.
//   The debounced level flips on the edge where the count reaches DEBOUNCE_CYCLES.
//   Press/release event = debounced level change.
//   Latency: raw change stable before edge 1 -> state/outputs change after edge DEBOUNCE_CYCLES+3.
//   Glitches shorter than DEBOUNCE_CYCLES synced samples are ignored.
//  Moore outputs decoded from the state register; Increment is a registered pulse.
//  States and outputs:
//   IDLE     : Enable_Count=all 1s, Dot=1, Reset=0, Blink=0
//   RESET_S  : Reset=1, Enable_Count=0, Blink=0, Dot=0
//   SET_k    : (k=1..NUM_FIELDS-1) Enable_Count=Blink=one-hot bit k, Reset=0, Dot=0
//  Transitions:
//   IDLE    -mode press->   RESET_S
//   RESET_S -mode release-> SET_1
//   RESET_S does not time out; it stays as long as the switch is held.
//   SET_k   -mode press->   SET_k+1; SET_(NUM_FIELDS-1) -mode press-> IDLE
//   Mode release in SET_k or IDLE: no effect.
//   SET_k   -timeout->      IDLE
//  Adjust (SET_k only):
//   Debounced press -> Increment high for exactly 1 cycle, on the edge after the debounced rise.
//   While held: next pulse REPEAT_DELAY cycles after the first, then every REPEAT_PERIOD cycles.
//   Release stops repeat immediately; the repeat counter is cleared.
//   In IDLE/RESET_S adjust is ignored; no pulse, including a hold carried into SET_1.
//   A new press is required.
//  Simultaneous mode event and adjust pulse in the same cycle: the state change wins; the pulse is suppressed.
//  Timeout counter: cleared on any debounced event of either switch and on every state change.
//   It is also held at 0 while adjust is held.
//   It increments in SET_k; reaching TIMEOUT_CYCLES -> IDLE on that edge.
//  Counters saturate, never wrap; widths come from $clog2 of their limits.
//  Switch held through reset release is seen as a fresh press after DEBOUNCE_CYCLES+3 edges.
// TESTING (NUM_FIELDS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=50, REPEAT_PERIOD=10, TIMEOUT_CYCLES=200)
//  1 Reset, then 3-cycle i_Switch glitch -> outputs stay Reset=0 Inc=0 Count=1111 Blink=0000 Dot=1.
//  2 Mode press (held 20) -> Reset=1 Count=0000 exactly 7 edges after press.
//    Release -> Count=Blink=0010; press -> 0100; release -> unchanged;
//    press -> 1000; press -> IDLE (1111, Dot=1).
//  3 In SET_1: adjust held 20 cycles -> exactly 1 Inc pulse.
//    Held 85 cycles -> pulses at offsets 0,50,60,70,80; none after release.
//  4 In SET_2, no activity -> IDLE exactly 200 edges after entry.
//    Adjust tap at cycle 150 -> timeout restarts from the tap's debounced release.
//  5 Assert i_Reset_n low mid SET_2 with adjust held -> outputs reset values with no clock edge.
//    Inc stays 0 after release.
//  6 Mode press and adjust press debounced on the same edge in SET_1 -> SET_2, Inc stays 0.
//    Adjust press in IDLE -> no pulse.

Source files
------------

// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - clock-setting controller: switch debounce, field select, adjust repeat, timeout
`timescale 1ns/1ps

module clock_set_controller_debounce #(
  parameter int CYCLES = 4
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Raw,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
);
  localparam int DW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [DW-1:0] r_count;

  // Level flips on the edge where the run of differing samples reaches CYCLES.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_count   <= '0;
    end else begin
      r_sync1   <= i_Raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 != r_level) begin
        if (r_count == DB_LAST) begin
          r_level <= r_sync2;
          r_count <= '0;
        end else begin
          r_count <= r_count + DW'(1);
        end
      end else begin
        r_count <= '0;
      end
    end
  end

  assign o_Level = r_level;
  assign o_Rise  = r_level & ~r_level_d;
  assign o_Fall  = ~r_level & r_level_d;
endmodule

module clock_set_controller #(
  parameter int NUM_FIELDS      = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_Switch,
  input  logic                  i_Adjust,
  output logic                  o_Counters_Reset,
  output logic                  o_Counters_Enable_Increment,
  output logic [NUM_FIELDS-1:0] o_Counters_Enable_Count,
  output logic [NUM_FIELDS-1:0] o_Display_Blink,
  output logic                  o_Display_Enable_Dot
);
  localparam int FW   = $clog2(NUM_FIELDS);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FIELD_FIRST = FW'(1);
  localparam logic [FW-1:0] FIELD_LAST  = FW'(NUM_FIELDS - 1);
  localparam logic [RW-1:0] RD_LAST     = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST     = RW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST     = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit            TO_ENABLE   = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {ST_IDLE, ST_RESET, ST_SET} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [FW-1:0]   r_field;
  logic [FW-1:0]   w_next_field;
  logic [RW-1:0]   r_repeat;
  logic            r_rep_first;
  logic            r_armed;
  logic [TW-1:0]   r_timeout;

  logic w_mode_level, w_mode_rise, w_mode_fall;
  logic w_adj_level, w_adj_rise, w_adj_fall;
  logic w_in_set, w_any_event, w_timeout_hit, w_state_change;
  logic w_press_pulse, w_repeat_live, w_repeat_hit;
  logic [NUM_FIELDS-1:0] w_onehot;
  logic [NUM_FIELDS-1:0] w_next_count;
  logic [NUM_FIELDS-1:0] w_next_blink;

  clock_set_controller_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .i_Clock  (i_Clock),
    .i_Reset_n(i_Reset_n),
    .i_Raw    (i_Switch),
    .o_Level  (w_mode_level),
    .o_Rise   (w_mode_rise),
    .o_Fall   (w_mode_fall)
  );

  clock_set_controller_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_adj_db (
    .i_Clock  (i_Clock),
    .i_Reset_n(i_Reset_n),
    .i_Raw    (i_Adjust),
    .o_Level  (w_adj_level),
    .o_Rise   (w_adj_rise),
    .o_Fall   (w_adj_fall)
  );

  assign w_in_set      = (r_state == ST_SET);
  assign w_any_event   = w_mode_rise | w_mode_fall | w_adj_rise | w_adj_fall;
  assign w_timeout_hit = TO_ENABLE && w_in_set && !w_any_event && !w_adj_level &&
                         (r_timeout == TO_LAST);

  always_comb begin
    w_next_state = r_state;
    w_next_field = r_field;
    case (r_state)
      ST_IDLE: begin
        if (w_mode_rise) w_next_state = ST_RESET;
      end
      ST_RESET: begin
        if (w_mode_fall) begin
          w_next_state = ST_SET;
          w_next_field = FIELD_FIRST;
        end
      end
      ST_SET: begin
        if (w_mode_rise) begin
          if (r_field == FIELD_LAST) begin
            w_next_state = ST_IDLE;
            w_next_field = '0;
          end else begin
            w_next_field = r_field + FW'(1);
          end
        end else if (w_timeout_hit) begin
          w_next_state = ST_IDLE;
          w_next_field = '0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_field = '0;
      end
    endcase
  end

  assign w_state_change = (w_next_state != r_state) || (w_next_field != r_field);
  assign w_onehot       = NUM_FIELDS'(1) << w_next_field;

  always_comb begin
    w_next_count = '0;
    w_next_blink = '0;
    if (w_next_state == ST_IDLE) begin
      w_next_count = '1;
    end else if (w_next_state == ST_SET) begin
      w_next_count = w_onehot;
      w_next_blink = w_onehot;
    end
  end

  // A mode event on the same edge as an adjust pulse wins; repeat only runs after a press seen in SET.
  assign w_press_pulse = w_in_set && w_adj_rise && !w_state_change;
  assign w_repeat_live = r_armed && w_adj_level && w_in_set && !w_state_change;
  assign w_repeat_hit  = r_rep_first ? (r_repeat == RD_LAST) : (r_repeat == RP_LAST);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state                     <= ST_IDLE;
      r_field                     <= '0;
      o_Counters_Reset            <= 1'b0;
      o_Counters_Enable_Increment <= 1'b0;
      o_Counters_Enable_Count     <= '1;
      o_Display_Blink             <= '0;
      o_Display_Enable_Dot        <= 1'b1;
    end else begin
      r_state                     <= w_next_state;
      r_field                     <= w_next_field;
      o_Counters_Reset            <= (w_next_state == ST_RESET);
      o_Counters_Enable_Increment <= w_press_pulse | (w_repeat_live & w_repeat_hit);
      o_Counters_Enable_Count     <= w_next_count;
      o_Display_Blink             <= w_next_blink;
      o_Display_Enable_Dot        <= (w_next_state == ST_IDLE);
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_repeat    <= '0;
      r_rep_first <= 1'b1;
      r_armed     <= 1'b0;
    end else if (w_press_pulse) begin
      r_repeat    <= '0;
      r_rep_first <= 1'b1;
      r_armed     <= 1'b1;
    end else if (w_repeat_live) begin
      if (w_repeat_hit) begin
        r_repeat    <= '0;
        r_rep_first <= 1'b0;
      end else begin
        r_repeat <= r_repeat + RW'(1);
      end
    end else begin
      r_repeat    <= '0;
      r_rep_first <= 1'b1;
      r_armed     <= 1'b0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_timeout <= '0;
    end else if (w_state_change || w_any_event || w_adj_level || !w_in_set) begin
      r_timeout <= '0;
    end else if (r_timeout != TO_LAST) begin
      r_timeout <= r_timeout + TW'(1);
    end
  end
endmodule

// File: tb/tb_clock_set_controller.sv
// tb/tb_clock_set_controller.sv - directed bench for clock_set_controller
`timescale 1ns/1ps

module tb_clock_set_controller;
  logic       clk;
  logic       rst_n;
  logic       sw;
  logic       adj;
  logic       o_rst;
  logic       o_inc;
  logic [3:0] o_cnt;
  logic [3:0] o_blink;
  logic       o_dot;
  logic [10:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_at[$];
  int exp85[5] = '{7, 57, 67, 77, 87};

  localparam logic [10:0] V_IDLE   = 11'b0_0_1111_0000_1;
  localparam logic [10:0] V_RST    = 11'b1_0_0000_0000_0;
  localparam logic [10:0] V_S1     = 11'b0_0_0010_0010_0;
  localparam logic [10:0] V_S2     = 11'b0_0_0100_0100_0;
  localparam logic [10:0] V_S3     = 11'b0_0_1000_1000_0;
  localparam logic [10:0] V_S2_INC = 11'b0_1_0100_0100_0;

  clock_set_controller #(
    .NUM_FIELDS     (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (50),
    .REPEAT_PERIOD  (10),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .i_Clock                    (clk),
    .i_Reset_n                  (rst_n),
    .i_Switch                   (sw),
    .i_Adjust                   (adj),
    .o_Counters_Reset           (o_rst),
    .o_Counters_Enable_Increment(o_inc),
    .o_Counters_Enable_Count    (o_cnt),
    .o_Display_Blink            (o_blink),
    .o_Display_Enable_Dot       (o_dot)
  );

  assign obs = {o_rst, o_inc, o_cnt, o_blink, o_dot};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic hold_adjust(input int hold, input int total);
    pulse_at.delete();
    adj = 1'b1;
    for (int i = 1; i <= total; i++) begin
      @(negedge clk);
      if (o_inc === 1'b1) pulse_at.push_back(i);
      if (i == hold) adj = 1'b0;
    end
  endtask

  task automatic mode_tap();
    sw = 1'b1; tick(10);
    sw = 1'b0; tick(10);
  endtask

  initial begin
    rst_n = 1'b1; sw = 1'b0; adj = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("reset_async", obs, V_IDLE);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("reset_idle", obs, V_IDLE);

    sw = 1'b1; tick(3); sw = 1'b0;
    tick(20);
    check("glitch_ignored", obs, V_IDLE);

    sw = 1'b1; tick(6);
    check("press_edge6", obs, V_IDLE);
    tick(1);
    check("press_edge7_reset", obs, V_RST);
    tick(13); sw = 1'b0; tick(6);
    check("release_edge6", obs, V_RST);
    tick(1);
    check("release_set1", obs, V_S1);
    tick(3); sw = 1'b1; tick(7);
    check("press_set2", obs, V_S2);
    tick(3); sw = 1'b0; tick(10);
    check("release_no_effect", obs, V_S2);
    sw = 1'b1; tick(7);
    check("press_set3", obs, V_S3);
    tick(3); sw = 1'b0; tick(10);
    sw = 1'b1; tick(7);
    check("press_wrap_idle", obs, V_IDLE);
    tick(3); sw = 1'b0; tick(10);
    check("idle_release", obs, V_IDLE);

    mode_tap();
    check("enter_set1", obs, V_S1);
    hold_adjust(20, 40);
    check("short_hold_count", pulse_at.size(), 1);
    check("short_hold_at", pulse_at[0], 7);
    hold_adjust(85, 130);
    check("long_hold_count", pulse_at.size(), 5);
    for (int k = 0; k < 5; k++) check($sformatf("long_hold_at%0d", k), pulse_at[k], exp85[k]);
    check("set1_after_adjust", obs, V_S1);

    sw = 1'b1; tick(7);
    check("to_entry_set2", obs, V_S2);
    tick(199);
    check("to_edge199", obs, V_S2);
    tick(1);
    check("to_edge200_idle", obs, V_IDLE);
    sw = 1'b0; tick(10);
    check("to_idle_release", obs, V_IDLE);

    mode_tap();
    sw = 1'b1; tick(7);
    check("tap_entry_set2", obs, V_S2);
    tick(143); adj = 1'b1; tick(5); adj = 1'b0;
    tick(2);
    check("tap_pulse", obs, V_S2_INC);
    tick(1);
    check("tap_pulse_end", obs, V_S2);
    tick(203);
    check("tap_restart_held", obs, V_S2);
    tick(1);
    check("tap_restart_idle", obs, V_IDLE);
    sw = 1'b0; tick(10);

    mode_tap();
    mode_tap();
    check("rst_enter_set2", obs, V_S2);
    adj = 1'b1; tick(10);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_set2", obs, V_IDLE);
    tick(2);
    rst_n = 1'b1;
    hold_adjust(1000, 30);
    check("rst_hold_no_pulse", pulse_at.size(), 0);
    check("rst_hold_idle", obs, V_IDLE);
    adj = 1'b0; tick(10);

    mode_tap();
    check("sim_enter_set1", obs, V_S1);
    sw = 1'b1; adj = 1'b1; tick(7);
    check("sim_state_wins", obs, V_S2);
    hold_adjust(1000, 70);
    check("sim_no_repeat", pulse_at.size(), 0);
    sw = 1'b0; adj = 1'b0; tick(10);
    check("sim_still_set2", obs, V_S2);
    mode_tap();
    mode_tap();
    check("back_to_idle", obs, V_IDLE);
    hold_adjust(20, 40);
    check("idle_adjust_ignored", pulse_at.size(), 0);
    check("idle_final", obs, V_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
